// File: rtl/sync_filter_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_filter_bank
// Description : Per-channel multi-flop synchroniser, consecutive-sample
//               filter, edge detect, and optional Gray-to-binary decode.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_filter_bank #(
    parameter int N      = 4,
    parameter int STAGES = 2,
    parameter int FILT   = 1,
    parameter int GRAY   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    output logic [N-1:0] q,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         chg,
    output logic [N-1:0] qbin
);

    localparam int            CW        = $clog2(FILT + 1);
    localparam logic [CW-1:0] c_CNT_MAX = CW'(FILT - 1);

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [STAGES-1:0] r_sync;
        logic [CW-1:0]     r_cnt;
        logic              r_q;
        logic              r_rise;
        logic              r_fall;
        logic              w_s;

        // Pure flop chain: nothing may sit between synchroniser stages.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[STAGES-2:0], din[i]};
            end
        end

        assign w_s = r_sync[STAGES-1];

        // Counter only advances while the synchronised level disagrees with q,
        // so any agreeing sample discards a partial deviation.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt  <= '0;
                r_q    <= 1'b0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else if (w_s == r_q) begin
                r_cnt  <= '0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_cnt  <= '0;
                r_q    <= w_s;
                r_rise <= w_s;
                r_fall <= ~w_s;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end
        end

        assign q[i]    = r_q;
        assign rise[i] = r_rise;
        assign fall[i] = r_fall;
    end : g_ch

    assign chg = |(rise | fall);

    if (GRAY != 0) begin : g_gray
        // Binary bit k is the parity of Gray bits k..N-1.
        for (genvar k = 0; k < N; k++) begin : g_bit
            assign qbin[k] = ^q[N-1:k];
        end : g_bit
    end else begin : g_plain
        assign qbin = q;
    end : g_plain

endmodule : sync_filter_bank
`default_nettype wire

// File: tb/tb_sync_filter_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sync_filter_bank
// Description : Scoreboard bench for sync_filter_bank with a window-based
//               reference model and asynchronous random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_filter_bank;

    localparam int N      = 4;
    localparam int STAGES = 2;
    localparam int FILT   = 3;
    localparam int GRAY   = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] din = '0;
    logic [N-1:0] q, rise, fall, qbin;
    logic         chg;

    sync_filter_bank #(.N(N), .STAGES(STAGES), .FILT(FILT), .GRAY(GRAY)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .chg  (chg),
        .qbin (qbin)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;

    // Reference model: captured din history plus a window of the last FILT
    // synchronised samples; a channel flips when the whole window disagrees.
    logic [N-1:0] pipe[$];
    logic [N-1:0] shist[$];
    logic [N-1:0] mq;

    function automatic logic [N-1:0] decode(input logic [N-1:0] g);
        logic [N-1:0] b;
        for (int k = 0; k < N; k++) b[k] = (GRAY != 0) ? ^(g >> k) : g[k];
        return b;
    endfunction

    task automatic model_reset();
        pipe.delete();
        repeat (STAGES) pipe.push_back('0);
        shist.delete();
        mq = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] s_now, er, ef;
        bit           all_diff;
        exp_t         e;
        s_now = pipe[STAGES-1];
        pipe.push_front(din);
        void'(pipe.pop_back());
        shist.push_back(s_now);
        if (shist.size() > FILT) void'(shist.pop_front());
        er = '0;
        ef = '0;
        for (int i = 0; i < N; i++) begin
            if (shist.size() == FILT) begin
                all_diff = 1'b1;
                for (int j = 0; j < FILT; j++)
                    if (shist[j][i] == mq[i]) all_diff = 1'b0;
                if (all_diff) begin
                    if (mq[i]) ef[i] = 1'b1;
                    else       er[i] = 1'b1;
                    mq[i] = ~mq[i];
                end
            end
        end
        e.q    = mq;
        e.rise = er;
        e.fall = ef;
        sb.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Monitor: one scoreboard entry per clock edge outside reset.
    always @(negedge clk) begin
        exp_t         e;
        logic [N-1:0] eb;
        logic         ec;
        if (!done) begin
            if (rst) begin
                e = '0;
            end else if (sb.size() == 0) begin
                e = '0;
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow at %0t: no expected entry", $time);
            end else begin
                e = sb.pop_front();
            end
            eb = decode(e.q);
            ec = |(e.rise | e.fall);
            n_checks++;
            if (q !== e.q || rise !== e.rise || fall !== e.fall || chg !== ec || qbin !== eb) begin
                n_fail++;
                $display("FAIL cycle_check at %0t rst=%0b: got q=%b rise=%b fall=%b chg=%b qbin=%b, expected q=%b rise=%b fall=%b chg=%b qbin=%b",
                         $time, rst, q, rise, fall, chg, qbin, e.q, e.rise, e.fall, ec, eb);
            end
        end
    end

    // Random din changes at arbitrary times that never coincide with a rising edge.
    task automatic drive(input int cycles, input int max_gap);
        longint t_end;
        int     d;
        t_end = $time + 64'(cycles) * 10;
        while ($time < t_end) begin
            d = int'($urandom_range(1, max_gap));
            if ((($time + d) % 10) == 5) d = d + 1;
            #(d);
            din = din ^ N'($urandom);
        end
    endtask

    task automatic async_reset_pulse();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (q !== '0 || rise !== '0 || fall !== '0 || chg !== 1'b0 || qbin !== '0) begin
            n_fail++;
            $display("FAIL async_reset at %0t: got q=%b rise=%b fall=%b chg=%b qbin=%b, expected all zero",
                     $time, q, rise, fall, chg, qbin);
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic hold(input logic [N-1:0] v, input int cycles);
        @(negedge clk);
        #3;
        din = v;
        repeat (cycles) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;

        drive(800, 120);
        drive(400, 25);
        async_reset_pulse();
        drive(600, 70);

        hold('1, 2);
        async_reset_pulse();
        hold('1, STAGES + FILT + 4);
        hold('0, STAGES + FILT + 4);

        hold(4'b0001, 10);
        hold(4'b0011, 10);
        hold(4'b0010, 10);
        hold(4'b0000, 2);
        hold(4'b0010, 10);

        drive(1500, 50);

        @(negedge clk);
        #1;
        done = 1'b1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_filter_bank
`default_nettype wire
